// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : KANADE32 memory-access pipeline stage. Takes one instruction at
//             a time, performs an aligned byte/half/word load or store on a
//             ready-handshaked data-memory port and produces a registered
//             write-back bundle. Misaligned accesses are dropped and reported.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             in_*                   - instruction from the EX/MEM register
//             stall                  - hold upstream while an access is open
//             mem_req/we/addr/be/wdata, mem_ready/rdata - data-memory port
//             out_valid/wb_data/dst_reg/reg_write - write-back bundle
//             misalign, bad_addr     - misaligned-access pulse and address
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_dst_reg,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_wb_data,
  output logic [4:0]        out_dst_reg,
  output logic              out_reg_write,
  output logic              misalign,
  output logic [31:0]       bad_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Fields of the outstanding access needed to build its write-back bundle
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic [1:0]        pend_size_q, pend_size_d;
  logic              pend_uns_q, pend_uns_d;
  logic              pend_m2r_q, pend_m2r_d;
  logic              pend_rw_q, pend_rw_d;
  logic [4:0]        pend_dst_q, pend_dst_d;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_wb_data_q, out_wb_data_d;
  logic [4:0]        out_dst_reg_q, out_dst_reg_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       bad_addr_q, bad_addr_d;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // --------------------------------------------------------------------------
  logic        is_mem;
  logic        is_load;
  logic        aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    is_mem  = in_mem_read | in_mem_write;
    // A request flagged as both read and write is handled as a load
    is_load = in_mem_read;

    case (in_size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~in_alu_result[0];
      default: aligned = (in_alu_result[1:0] == 2'b00);
    endcase

    case (in_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << in_alu_result[1:0];
        req_wdata = {4{in_store_data[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << {in_alu_result[1], 1'b0};
        req_wdata = {2{in_store_data[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = in_store_data;
      end
    endcase

    // Loads always fetch the full word; the lane is picked on return
    if (is_load) begin
      req_be = 4'b1111;
    end
  end

  // --------------------------------------------------------------------------
  // Load data alignment and extension
  // --------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  always_comb begin
    case (pend_addr_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = pend_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (pend_size_q)
      SZ_BYTE: ld_value = {{24{~pend_uns_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = {{16{~pend_uns_q & ld_half[15]}}, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;
    pend_addr_d     = pend_addr_q;
    pend_size_d     = pend_size_q;
    pend_uns_d      = pend_uns_q;
    pend_m2r_d      = pend_m2r_q;
    pend_rw_d       = pend_rw_q;
    pend_dst_d      = pend_dst_q;
    out_valid_d     = 1'b0;
    out_wb_data_d   = out_wb_data_q;
    out_dst_reg_d   = out_dst_reg_q;
    out_reg_write_d = out_reg_write_q;
    misalign_d      = 1'b0;
    bad_addr_d      = bad_addr_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d     = 1'b1;
            out_wb_data_d   = in_alu_result;
            out_dst_reg_d   = in_dst_reg;
            out_reg_write_d = in_reg_write;
          end else if (!aligned) begin
            // Dropped access still retires so the pipeline keeps moving
            out_valid_d     = 1'b1;
            out_dst_reg_d   = in_dst_reg;
            out_reg_write_d = 1'b0;
            misalign_d      = 1'b1;
            bad_addr_d      = in_alu_result;
          end else begin
            state_d     = BUSY;
            mem_we_d    = ~is_load;
            mem_addr_d  = in_alu_result[ADDR_W+1:2];
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            pend_addr_d = in_alu_result;
            pend_size_d = in_size;
            pend_uns_d  = in_unsigned;
            pend_m2r_d  = in_mem_to_reg;
            pend_rw_d   = in_reg_write & is_load;
            pend_dst_d  = in_dst_reg;
          end
        end
      end
      default: begin
        if (mem_ready) begin
          state_d         = IDLE;
          out_valid_d     = 1'b1;
          out_dst_reg_d   = pend_dst_q;
          out_reg_write_d = pend_rw_q;
          if (!mem_we_q) begin
            out_wb_data_d = pend_m2r_q ? ld_value : pend_addr_q;
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_be_q        <= 4'b0000;
      mem_wdata_q     <= 32'h0;
      pend_addr_q     <= 32'h0;
      pend_size_q     <= 2'b00;
      pend_uns_q      <= 1'b0;
      pend_m2r_q      <= 1'b0;
      pend_rw_q       <= 1'b0;
      pend_dst_q      <= 5'd0;
      out_valid_q     <= 1'b0;
      out_wb_data_q   <= 32'h0;
      out_dst_reg_q   <= 5'd0;
      out_reg_write_q <= 1'b0;
      misalign_q      <= 1'b0;
      bad_addr_q      <= 32'h0;
    end else begin
      state_q         <= state_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
      pend_addr_q     <= pend_addr_d;
      pend_size_q     <= pend_size_d;
      pend_uns_q      <= pend_uns_d;
      pend_m2r_q      <= pend_m2r_d;
      pend_rw_q       <= pend_rw_d;
      pend_dst_q      <= pend_dst_d;
      out_valid_q     <= out_valid_d;
      out_wb_data_q   <= out_wb_data_d;
      out_dst_reg_q   <= out_dst_reg_d;
      out_reg_write_q <= out_reg_write_d;
      misalign_q      <= misalign_d;
      bad_addr_q      <= bad_addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The request is open for exactly the cycles spent in BUSY
  assign stall         = (state_q == BUSY);
  assign mem_req       = (state_q == BUSY);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign out_valid     = out_valid_q;
  assign out_wb_data   = out_wb_data_q;
  assign out_dst_reg   = out_dst_reg_q;
  // Write enable is only ever seen together with a valid bundle
  assign out_reg_write = out_reg_write_q & out_valid_q;
  assign misalign      = misalign_q;
  assign bad_addr      = bad_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Directed self-checking bench for mem_access_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dst_reg;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_wb_data;
  logic [4:0]  out_dst_reg;
  logic        out_reg_write;
  logic        misalign;
  logic [31:0] bad_addr;

  int checks = 0;
  int passed = 0;

  mem_access_stage #(.ADDR_W(30)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_dst_reg    (in_dst_reg),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_reg_write  (in_reg_write),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_wb_data   (out_wb_data),
    .out_dst_reg   (out_dst_reg),
    .out_reg_write (out_reg_write),
    .misalign      (misalign),
    .bad_addr      (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_alu_result = 32'h0;
    in_store_data = 32'h0;
    in_dst_reg    = 5'd0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_reg_write  = 1'b0;
    in_size       = 2'b00;
    in_unsigned   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] dst,
                       input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [1:0] sz, input logic uns);
    in_valid      = 1'b1;
    in_alu_result = addr;
    in_store_data = sdata;
    in_dst_reg    = dst;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_size       = sz;
    in_unsigned   = uns;
  endtask

  initial begin
    idle_inputs();
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_stall",     {31'b0, stall},     32'd0);
    check("rst_mem_req",   {31'b0, mem_req},   32'd0);
    check("rst_bad_addr",  bad_addr,           32'h0);
    check("rst_wb_data",   out_wb_data,        32'h0);

    // Non-memory op, latency 1
    issue(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    check("alu_valid", {31'b0, out_valid},     32'd1);
    check("alu_wb",    out_wb_data,            32'h0000_1234);
    check("alu_dst",   {27'b0, out_dst_reg},   32'd5);
    check("alu_rw",    {31'b0, out_reg_write}, 32'd1);
    check("alu_stall", {31'b0, stall},         32'd0);
    tick();
    check("alu_pulse", {31'b0, out_valid},     32'd0);

    // Word load at 0x100, ready on the third request cycle
    issue(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    check("wl_req1",   {31'b0, mem_req}, 32'd1);
    check("wl_stall1", {31'b0, stall},   32'd1);
    check("wl_addr",   {2'b0, mem_addr}, 32'h40);
    check("wl_be",     {28'b0, mem_be},  32'hF);
    check("wl_we",     {31'b0, mem_we},  32'd0);
    tick();
    check("wl_stall2", {31'b0, stall},     32'd1);
    check("wl_novalid",{31'b0, out_valid}, 32'd0);
    tick();
    check("wl_stall3", {31'b0, stall},   32'd1);
    check("wl_req3",   {31'b0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check("wl_valid",  {31'b0, out_valid},     32'd1);
    check("wl_wb",     out_wb_data,            32'hDEAD_BEEF);
    check("wl_dst",    {27'b0, out_dst_reg},   32'd7);
    check("wl_rw",     {31'b0, out_reg_write}, 32'd1);
    check("wl_stall0", {31'b0, stall},         32'd0);
    check("wl_req0",   {31'b0, mem_req},       32'd0);
    tick();
    check("wl_pulse",  {31'b0, out_valid},     32'd0);

    // Signed byte load at 0x103, zero-wait
    issue(32'h0000_0103, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    tick();
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'h80AA_BBCC;
    tick();
    mem_ready = 1'b0;
    check("lbs_valid", {31'b0, out_valid}, 32'd1);
    check("lbs_wb",    out_wb_data,        32'hFFFF_FF80);

    // Unsigned byte load at 0x103, zero-wait
    issue(32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    tick();
    idle_inputs();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lbu_valid", {31'b0, out_valid}, 32'd1);
    check("lbu_wb",    out_wb_data,        32'h0000_0080);

    // Signed half load at 0x102 from the same word: upper half 0x80AA
    issue(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    tick();
    idle_inputs();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lhs_wb", out_wb_data, 32'hFFFF_80AA);

    // Half store of 0x1234ABCD at 0x202
    issue(32'h0000_0202, 32'h1234_ABCD, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    tick();
    idle_inputs();
    check("sh_we",    {31'b0, mem_we},  32'd1);
    check("sh_be",    {28'b0, mem_be},  32'hC);
    check("sh_wdata", mem_wdata,        32'hABCD_ABCD);
    check("sh_addr",  {2'b0, mem_addr}, 32'h80);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sh_valid", {31'b0, out_valid},     32'd1);
    check("sh_rw",    {31'b0, out_reg_write}, 32'd0);

    // Byte store at 0x301: lane 1, data replicated
    issue(32'h0000_0301, 32'h0000_005A, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    idle_inputs();
    check("sb_be",    {28'b0, mem_be}, 32'h2);
    check("sb_wdata", mem_wdata,       32'h5A5A_5A5A);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // Misaligned word load at 0x105
    issue(32'h0000_0105, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    check("mis_req",   {31'b0, mem_req},       32'd0);
    check("mis_pulse", {31'b0, misalign},      32'd1);
    check("mis_bad",   bad_addr,               32'h0000_0105);
    check("mis_valid", {31'b0, out_valid},     32'd1);
    check("mis_rw",    {31'b0, out_reg_write}, 32'd0);
    check("mis_stall", {31'b0, stall},         32'd0);
    tick();
    check("mis_clear", {31'b0, misalign},      32'd0);
    check("mis_hold",  bad_addr,               32'h0000_0105);

    // Reset while BUSY abandons the access
    issue(32'h0000_0010, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    check("rb_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_req0",   {31'b0, mem_req},   32'd0);
    check("rb_stall0", {31'b0, stall},     32'd0);
    check("rb_valid0", {31'b0, out_valid}, 32'd0);
    tick();
    check("rb_valid1", {31'b0, out_valid}, 32'd0);

    // Subsequent load completes normally
    issue(32'h0000_0020, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    check("pl_addr", {2'b0, mem_addr}, 32'h8);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_55AA;
    tick();
    mem_ready = 1'b0;
    check("pl_valid", {31'b0, out_valid},   32'd1);
    check("pl_wb",    out_wb_data,          32'h0000_55AA);
    check("pl_dst",   {27'b0, out_dst_reg}, 32'd11);

    // Load with mem_to_reg=0 writes back the address
    issue(32'h0000_0044, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    tick();
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0;
    check("m2r0_wb", out_wb_data, 32'h0000_0044);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the KANADE32 pipeline. It sits downstream of the execute/memory-access stage register and upstream of register write-back.
- Takes the ALU result, store data and decoded control for one instruction at a time. Performs a load or store on a ready-handshaked data-memory port (byte-enabled, little-endian).
- Produces a registered write-back bundle and raises `stall` to freeze upstream stages while an access is outstanding.

Parameters:
- ADDR_W, 30, word-address width driven on mem_addr (byte address bits [ADDR_W+1:2])

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present on in_* this cycle
- in_alu_result  in  32  effective byte address (loads/stores) or result to write back
- in_store_data  in  32  register data for stores
- in_dst_reg  in  5  destination register number
- in_mem_read  in  1  load
- in_mem_write  in  1  store (in_mem_read and in_mem_write never both 1; if so, treat as load)
- in_mem_to_reg  in  1  write-back value comes from memory
- in_reg_write  in  1  instruction writes a register
- in_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- in_unsigned  in  1  zero-extend narrow loads (else sign-extend)
- stall  out  1  upstream must hold its stage registers
- mem_req  out  1  access request, held until mem_ready
- mem_we  out  1  1 store, 0 load
- mem_addr  out  ADDR_W  word address
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  store data, lane-replicated
- mem_ready  in  1  access completes this cycle (rdata valid for loads)
- mem_rdata  in  32  read word
- out_valid  out  1  write-back bundle valid (one-cycle pulse per instruction)
- out_wb_data  out  32  value to write back
- out_dst_reg  out  5  destination register
- out_reg_write  out  1  register write enable (already qualified by out_valid)
- misalign  out  1  one-cycle pulse: misaligned access dropped
- bad_addr  out  32  byte address of the last misaligned access

Behaviour:
- FSM states:
  - IDLE → BUSY: in_valid and a memory op and aligned.
  - BUSY → IDLE: mem_ready.
- Reset: state IDLE; all outputs 0, bad_addr 0. Reset mid-access: mem_req drops the cycle after reset is sampled; the access is abandoned and no out_valid is produced.
- stall = (state==BUSY), registered-state only, no combinational path from in_*.
- IDLE accepts in_valid every cycle. Input is never accepted in BUSY, including the mem_ready cycle; the held instruction is accepted the cycle after return to IDLE.
- Non-memory op (in_valid, neither read nor write): next cycle out_valid=1, out_wb_data=in_alu_result, out_dst_reg, out_reg_write=in_reg_write. Latency 1.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned memory op:
  - no mem_req;
  - next cycle out_valid=1 with out_reg_write=0, misalign=1, bad_addr=addr;
  - state stays IDLE.
- Memory op accept (cycle 0): request fields are registered.
  - mem_req=1 from cycle 1 until the cycle mem_ready=1 inclusive.
  - mem_addr, mem_we, mem_be, mem_wdata are stable throughout the request.
  - Zero-wait: mem_ready in cycle 1 gives out_valid in cycle 2.
- Store:
  - mem_be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
  - mem_wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - out_valid pulses the cycle after mem_ready with out_reg_write=0.
- Load:
  - mem_be=1111; mem_rdata is sampled only in the mem_ready cycle.
  - Byte: lane addr[1:0]; half: lane addr[1]. Sign- or zero-extend per in_unsigned.
  - Result registered to out_wb_data the cycle after mem_ready.
  - out_reg_write = registered in_reg_write. If in_mem_to_reg=0, write back the address (alu result) instead.
- out_valid is never 1 on two consecutive cycles for a memory op. All outputs other than out_valid/misalign/mem_req hold their last values when idle.

Test Plan:
- Non-memory op: in_valid, alu=0x0000_1234, dst=5, reg_write=1 → next cycle out_valid=1, wb=0x1234, dst=5; stall never 1.
- Word load at 0x100, mem_ready on 3rd request cycle, rdata=0xDEADBEEF:
  - mem_addr=0x40, be=1111;
  - stall for 3 cycles;
  - out_valid the cycle after ready, wb=0xDEADBEEF.
- Byte loads at 0x103, rdata=0x80AA_BBCC, zero-wait:
  - signed → wb=0xFFFF_FF80;
  - unsigned → 0x0000_0080.
- Half store of 0x1234_ABCD at 0x202 → mem_we=1, be=1100, wdata=0xABCD_ABCD, out_reg_write=0.
- Misaligned word load at 0x105 → no mem_req; misalign pulse; bad_addr=0x105; out_valid with out_reg_write=0.
- Reset asserted while BUSY with mem_ready=0 → next cycle mem_req=0, stall=0, no out_valid; a subsequent load completes normally.
